// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared types for the ethernet ingress packet buffer
package eth_pkg;

    localparam int ETH_DATA_W = 32;

    typedef struct packed {
        logic                  sop;
        logic                  eop;
        logic [ETH_DATA_W-1:0] data;
    } eth_word_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_PKT,
        W_DROP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_SEND
    } rd_state_t;

endpackage

// File: rtl/eth_pkt_ram.sv
// rtl/eth_pkt_ram.sv - packet word storage, one write port, combinational read
module eth_pkt_ram #(
    parameter  int DEPTH = 64,
    parameter  int WIDTH = 34,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/eth_ingress_pkt_buffer.sv
// rtl/eth_ingress_pkt_buffer.sv - store-and-forward ingress buffer for one switch port
module eth_ingress_pkt_buffer
    import eth_pkg::*;
#(
    parameter  int DATA_W = ETH_DATA_W,
    parameter  int DEPTH  = 64,
    parameter  int CNT_W  = 16,
    localparam int AW     = $clog2(DEPTH),
    localparam int PW     = AW + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sop,
    input  logic              in_eop,
    input  logic              stall,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sop,
    output logic              out_eop,
    output logic [PW-1:0]     pkt_cnt,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic              full
);

    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam int SOP_B = DATA_W + 1;
    localparam int EOP_B = DATA_W;

    wr_state_t         wr_state, wr_state_nxt;
    rd_state_t         rd_state, rd_state_nxt;
    logic [PW-1:0]     wr_cmt, wr_tmp, rd_ptr;
    logic [PW-1:0]     wr_base, wr_tmp_nxt, wr_cmt_nxt;
    logic              ram_we, commit, pop;
    logic [1:0]        drop_inc;
    logic [CNT_W:0]    drop_sum;
    logic [DATA_W+1:0] rd_word;

    assign full     = (wr_tmp - rd_ptr) == DEPTH_P;
    assign drop_sum = {1'b0, drop_cnt} + (CNT_W+1)'(drop_inc);

    eth_pkt_ram #(.DEPTH(DEPTH), .WIDTH(DATA_W + 2)) u_ram (
        .clk     (clk),
        .wr_en   (ram_we),
        .wr_addr (wr_base[AW-1:0]),
        .wr_data ({in_sop, in_eop, in_data}),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (rd_word)
    );

    // A sop always starts a new packet; inside W_PKT it first rewinds the partial one.
    always_comb begin
        wr_state_nxt = wr_state;
        wr_tmp_nxt   = wr_tmp;
        wr_cmt_nxt   = wr_cmt;
        wr_base      = wr_tmp;
        ram_we       = 1'b0;
        commit       = 1'b0;
        drop_inc     = 2'd0;
        if (in_valid) begin
            if (in_sop) begin
                if (wr_state == W_PKT) begin
                    wr_base  = wr_cmt;
                    drop_inc = 2'd1;
                end
                if ((wr_base - rd_ptr) == DEPTH_P) begin
                    drop_inc     = drop_inc + 2'd1;
                    wr_tmp_nxt   = wr_base;
                    wr_state_nxt = in_eop ? W_IDLE : W_DROP;
                end else begin
                    ram_we     = 1'b1;
                    wr_tmp_nxt = wr_base + PW'(1);
                    if (in_eop) begin
                        commit       = 1'b1;
                        wr_cmt_nxt   = wr_base + PW'(1);
                        wr_state_nxt = W_IDLE;
                    end else begin
                        wr_state_nxt = W_PKT;
                    end
                end
            end else if (wr_state == W_PKT) begin
                if (full) begin
                    wr_tmp_nxt   = wr_cmt;
                    drop_inc     = 2'd1;
                    wr_state_nxt = in_eop ? W_IDLE : W_DROP;
                end else begin
                    ram_we     = 1'b1;
                    wr_tmp_nxt = wr_tmp + PW'(1);
                    if (in_eop) begin
                        commit       = 1'b1;
                        wr_cmt_nxt   = wr_tmp + PW'(1);
                        wr_state_nxt = W_IDLE;
                    end
                end
            end else if (wr_state == W_DROP && in_eop) begin
                wr_state_nxt = W_IDLE;
            end
        end
    end

    always_comb begin
        rd_state_nxt = rd_state;
        pop          = 1'b0;
        case (rd_state)
            R_IDLE:  pop = (pkt_cnt != '0) && !stall;
            R_SEND:  pop = !stall;
            default: pop = 1'b0;
        endcase
        if (pop) rd_state_nxt = rd_word[EOP_B] ? R_IDLE : R_SEND;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_state  <= W_IDLE;
            rd_state  <= R_IDLE;
            wr_cmt    <= '0;
            wr_tmp    <= '0;
            rd_ptr    <= '0;
            pkt_cnt   <= '0;
            drop_cnt  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
        end else begin
            wr_state  <= wr_state_nxt;
            rd_state  <= rd_state_nxt;
            wr_cmt    <= wr_cmt_nxt;
            wr_tmp    <= wr_tmp_nxt;
            out_valid <= pop;
            if (drop_inc != 2'd0) begin
                drop_cnt <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
            end
            // A commit coinciding with the last pop of another packet leaves the count unchanged.
            if (commit && !(pop && rd_word[EOP_B])) begin
                pkt_cnt <= pkt_cnt + PW'(1);
            end else if (!commit && pop && rd_word[EOP_B]) begin
                pkt_cnt <= pkt_cnt - PW'(1);
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + PW'(1);
                out_data <= rd_word[DATA_W-1:0];
                out_sop  <= rd_word[SOP_B];
                out_eop  <= rd_word[EOP_B];
            end else begin
                out_sop <= 1'b0;
                out_eop <= 1'b0;
            end
        end
    end

endmodule
